// File: rtl/csr_pkg.sv
// Shared constants, payload types and address-decode helpers for the machine-mode CSR file.
// CSR_COUNTERS_EN selects whether the 64-bit counter addresses decode as implemented.
package csr_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 12;

    localparam logic [ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [ADDR_W-1:0] CSR_MISA      = 12'h301;
    localparam logic [ADDR_W-1:0] CSR_MIE       = 12'h304;
    localparam logic [ADDR_W-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [ADDR_W-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [ADDR_W-1:0] CSR_MEPC      = 12'h341;
    localparam logic [ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [ADDR_W-1:0] CSR_MTVAL     = 12'h343;
    localparam logic [ADDR_W-1:0] CSR_MIP       = 12'h344;
    localparam logic [ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
    localparam logic [ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
    localparam logic [ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MSTATUS_MPP_LSB  = 11;
    localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;

    localparam logic [XLEN-1:0] MSTATUS_WMASK   = (32'd1 << MSTATUS_MIE_BIT) | (32'd1 << MSTATUS_MPIE_BIT);
    localparam logic [XLEN-1:0] MSTATUS_RO_BITS = 32'(MSTATUS_MPP_M) << MSTATUS_MPP_LSB;
    localparam logic [XLEN-1:0] ALIGN4_MASK     = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] MCAUSE_ECALL_M  = 32'd11;

    localparam logic [XLEN-1:0] CSR_RST_VAL    = '0;
    localparam logic [XLEN-1:0] MSTATUS_RST_RD = CSR_RST_VAL | MSTATUS_RO_BITS;

    typedef struct packed {
        logic            hit;
        logic [XLEN-1:0] data;
    } csr_wr_t;

    // Winning write for one CSR: port 1 (index 0) has the highest priority.
    function automatic csr_wr_t csr_pick(input logic [ADDR_W-1:0] target,
                                         input logic [2:0] we,
                                         input logic [2:0][ADDR_W-1:0] addr,
                                         input logic [2:0][XLEN-1:0] wd);
        csr_wr_t r;
        r.hit  = 1'b0;
        r.data = '0;
        if (we[2] && addr[2] == target) begin r.hit = 1'b1; r.data = wd[2]; end
        if (we[1] && addr[1] == target) begin r.hit = 1'b1; r.data = wd[1]; end
        if (we[0] && addr[0] == target) begin r.hit = 1'b1; r.data = wd[0]; end
        return r;
    endfunction

    function automatic logic csr_is_impl(input logic [ADDR_W-1:0] a);
        case (a)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
            CSR_MCAUSE, CSR_MTVAL, CSR_MIP, CSR_MHARTID: return 1'b1;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Address space 0xC00-0xFFF is read-only by encoding.
    function automatic logic csr_is_ro(input logic [ADDR_W-1:0] a);
        return a[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent low/high word software writes.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wd_lo_i,
    input  logic [31:0] wd_hi_i,
    output logic [63:0] cnt_o
);
    logic [63:0] cnt_q, cnt_d;

    // A write to either half suppresses the increment; the other half holds.
    always_comb begin
        cnt_d = cnt_q;
        if (we_lo_i || we_hi_i) begin
            if (we_lo_i) cnt_d[31:0]  = wd_lo_i;
            if (we_hi_i) cnt_d[63:32] = wd_hi_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: three combinational read ports, prioritised writes, 64-bit counters.
// Define CSR_COUNTERS_EN to build mcycle/minstret and their user-mode shadows.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [XLEN-1:0] HART_ID    = 32'h0,
    parameter logic [XLEN-1:0] MISA_VALUE = 32'h4000_0100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instret,
    input  logic [ADDR_W-1:0] csr_addr1,
    input  logic [ADDR_W-1:0] csr_addr2,
    input  logic [ADDR_W-1:0] csr_addr3,
    input  logic              csr_we1,
    input  logic              csr_we2,
    input  logic              csr_we3,
    input  logic [XLEN-1:0]   csr_wd1,
    input  logic [XLEN-1:0]   csr_wd2,
    input  logic [XLEN-1:0]   csr_wd3,
    output logic [XLEN-1:0]   csr_rd1,
    output logic [XLEN-1:0]   csr_rd2,
    output logic [XLEN-1:0]   csr_rd3,
    output logic              illegal1
);
    logic [2:0]             we_v;
    logic [2:0][ADDR_W-1:0] addr_v;
    logic [2:0][XLEN-1:0]   wd_v;

    assign we_v   = {csr_we3, csr_we2, csr_we1};
    assign addr_v = {csr_addr3, csr_addr2, csr_addr1};
    assign wd_v   = {csr_wd3, csr_wd2, csr_wd1};

    csr_wr_t w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause, w_mtval;

    assign w_mstatus  = csr_pick(CSR_MSTATUS,  we_v, addr_v, wd_v);
    assign w_mie      = csr_pick(CSR_MIE,      we_v, addr_v, wd_v);
    assign w_mtvec    = csr_pick(CSR_MTVEC,    we_v, addr_v, wd_v);
    assign w_mscratch = csr_pick(CSR_MSCRATCH, we_v, addr_v, wd_v);
    assign w_mepc     = csr_pick(CSR_MEPC,     we_v, addr_v, wd_v);
    assign w_mcause   = csr_pick(CSR_MCAUSE,   we_v, addr_v, wd_v);
    assign w_mtval    = csr_pick(CSR_MTVAL,    we_v, addr_v, wd_v);

    logic [XLEN-1:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mstatus_q  <= CSR_RST_VAL;
            mie_q      <= CSR_RST_VAL;
            mtvec_q    <= CSR_RST_VAL;
            mscratch_q <= CSR_RST_VAL;
            mepc_q     <= CSR_RST_VAL;
            mcause_q   <= CSR_RST_VAL;
            mtval_q    <= CSR_RST_VAL;
        end else begin
            if (w_mstatus.hit)  mstatus_q  <= w_mstatus.data & MSTATUS_WMASK;
            if (w_mie.hit)      mie_q      <= w_mie.data;
            if (w_mtvec.hit)    mtvec_q    <= w_mtvec.data & ALIGN4_MASK;
            if (w_mscratch.hit) mscratch_q <= w_mscratch.data;
            if (w_mepc.hit)     mepc_q     <= w_mepc.data & ALIGN4_MASK;
            if (w_mcause.hit)   mcause_q   <= w_mcause.data;
            if (w_mtval.hit)    mtval_q    <= w_mtval.data;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_wr_t     w_mcycle, w_mcycleh, w_minstret, w_minstreth;
    logic [63:0] mcycle, minstret;

    assign w_mcycle    = csr_pick(CSR_MCYCLE,    we_v, addr_v, wd_v);
    assign w_mcycleh   = csr_pick(CSR_MCYCLEH,   we_v, addr_v, wd_v);
    assign w_minstret  = csr_pick(CSR_MINSTRET,  we_v, addr_v, wd_v);
    assign w_minstreth = csr_pick(CSR_MINSTRETH, we_v, addr_v, wd_v);

    csr_counter64 u_cycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .we_lo_i (w_mcycle.hit),
        .we_hi_i (w_mcycleh.hit),
        .wd_lo_i (w_mcycle.data),
        .wd_hi_i (w_mcycleh.data),
        .cnt_o   (mcycle)
    );

    csr_counter64 u_instret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (instret),
        .we_lo_i (w_minstret.hit),
        .we_hi_i (w_minstreth.hit),
        .wd_lo_i (w_minstret.data),
        .wd_hi_i (w_minstreth.data),
        .cnt_o   (minstret)
    );
`else
    logic unused_instret;
    assign unused_instret = instret;
`endif

    // One read mux per port; all reads see pre-edge state.
    for (genvar p = 0; p < 3; p++) begin : g_rd
        logic [XLEN-1:0] rd;
        always_comb begin
            rd = '0;
            case (addr_v[p])
                CSR_MSTATUS:  rd = mstatus_q | MSTATUS_RO_BITS;
                CSR_MISA:     rd = MISA_VALUE;
                CSR_MIE:      rd = mie_q;
                CSR_MTVEC:    rd = mtvec_q;
                CSR_MSCRATCH: rd = mscratch_q;
                CSR_MEPC:     rd = mepc_q;
                CSR_MCAUSE:   rd = mcause_q;
                CSR_MTVAL:    rd = mtval_q;
                CSR_MHARTID:  rd = HART_ID;
`ifdef CSR_COUNTERS_EN
                CSR_MCYCLE,    CSR_CYCLE:    rd = mcycle[31:0];
                CSR_MCYCLEH,   CSR_CYCLEH:   rd = mcycle[63:32];
                CSR_MINSTRET,  CSR_INSTRET:  rd = minstret[31:0];
                CSR_MINSTRETH, CSR_INSTRETH: rd = minstret[63:32];
`endif
                default:      rd = '0;
            endcase
        end
    end

    assign csr_rd1 = g_rd[0].rd;
    assign csr_rd2 = g_rd[1].rd;
    assign csr_rd3 = g_rd[2].rd;

    assign illegal1 = !csr_is_impl(csr_addr1) || (csr_we1 && csr_is_ro(csr_addr1));

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed vector table, counter sequences, randomized model check.
module tb_csr_file;
    import csr_pkg::*;

    localparam logic [31:0] MISA_EXP = 32'h4000_0100;
    localparam logic [31:0] HART_EXP = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n, instret;
    logic [11:0] a1, a2, a3;
    logic        w1, w2, w3;
    logic [31:0] d1, d2, d3;
    logic [31:0] rd1, rd2, rd3;
    logic        ill1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csr_file #(.HART_ID(32'h0), .MISA_VALUE(32'h4000_0100)) dut (
        .clk(clk), .rst_n(rst_n), .instret(instret),
        .csr_addr1(a1), .csr_addr2(a2), .csr_addr3(a3),
        .csr_we1(w1), .csr_we2(w2), .csr_we3(w3),
        .csr_wd1(d1), .csr_wd2(d2), .csr_wd3(d3),
        .csr_rd1(rd1), .csr_rd2(rd2), .csr_rd3(rd3),
        .illegal1(ill1)
    );

    typedef struct {
        string       name;
        logic [11:0] a1, a2, a3;
        logic        w1, w2, w3;
        logic [31:0] d1, d2, d3;
        logic [31:0] e1, e2, e3;
        logic        eill;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm,
                                logic [11:0] x1, logic y1, logic [31:0] z1,
                                logic [11:0] x2, logic y2, logic [31:0] z2,
                                logic [11:0] x3, logic y3, logic [31:0] z3,
                                logic [31:0] e1, logic [31:0] e2, logic [31:0] e3, logic eill);
        vec_t v;
        v.name = nm;
        v.a1 = x1; v.w1 = y1; v.d1 = z1;
        v.a2 = x2; v.w2 = y2; v.d2 = z2;
        v.a3 = x3; v.w3 = y3; v.d3 = z3;
        v.e1 = e1; v.e2 = e2; v.e3 = e3; v.eill = eill;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [11:0] x1, input logic y1, input logic [31:0] z1,
                         input logic [11:0] x2, input logic y2, input logic [31:0] z2,
                         input logic [11:0] x3, input logic y3, input logic [31:0] z3);
        a1 = x1; w1 = y1; d1 = z1;
        a2 = x2; w2 = y2; d2 = z2;
        a3 = x3; w3 = y3; d3 = z3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string nm, input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] e3, input logic eill);
        chk({nm, ".rd1"}, rd1, e1);
        chk({nm, ".rd2"}, rd2, e2);
        chk({nm, ".rd3"}, rd3, e3);
        chk({nm, ".ill"}, 32'(ill1), 32'(eill));
    endtask

    // Reference model: architectural CSR values, updated from the behavioural rules.
    logic [31:0] m_mst, m_mie, m_mtvec, m_mscr, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;

    function automatic logic m_impl(input logic [11:0] a);
`ifdef CSR_COUNTERS_EN
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                         12'hC00, 12'hC80, 12'hC02, 12'hC82};
`else
        return a inside {12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'h343, 12'h344, 12'hF14};
`endif
    endfunction

    function automatic logic m_illegal(input logic [11:0] a, input logic we);
        return !m_impl(a) || (we && a >= 12'hC00);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mst | 32'h0000_1800;
            12'h301: return MISA_EXP;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hF14: return HART_EXP;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_mst = 0; m_mie = 0; m_mtvec = 0; m_mscr = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_ins = 0;
    endtask

    // Apply the ports' writes lowest-priority first so port 1 lands last.
    task automatic m_step();
        logic [11:0] aa[3];
        logic        ww[3];
        logic [31:0] dd[3];
        logic [63:0] nc, ni;
        logic        cw, iw;
        if (!rst_n) begin
            m_reset();
            return;
        end
        aa[0] = a1; aa[1] = a2; aa[2] = a3;
        ww[0] = w1; ww[1] = w2; ww[2] = w3;
        dd[0] = d1; dd[1] = d2; dd[2] = d3;
        nc = m_cyc; ni = m_ins; cw = 1'b0; iw = 1'b0;
        for (int p = 2; p >= 0; p--) begin
            if (ww[p]) begin
                case (aa[p])
                    12'h300: m_mst    = dd[p] & 32'h0000_0088;
                    12'h304: m_mie    = dd[p];
                    12'h305: m_mtvec  = {dd[p][31:2], 2'b00};
                    12'h340: m_mscr   = dd[p];
                    12'h341: m_mepc   = {dd[p][31:2], 2'b00};
                    12'h342: m_mcause = dd[p];
                    12'h343: m_mtval  = dd[p];
`ifdef CSR_COUNTERS_EN
                    12'hB00: begin nc[31:0]  = dd[p]; cw = 1'b1; end
                    12'hB80: begin nc[63:32] = dd[p]; cw = 1'b1; end
                    12'hB02: begin ni[31:0]  = dd[p]; iw = 1'b1; end
                    12'hB82: begin ni[63:32] = dd[p]; iw = 1'b1; end
`endif
                    default: ;
                endcase
            end
        end
`ifdef CSR_COUNTERS_EN
        m_cyc = cw ? nc : m_cyc + 64'd1;
        m_ins = iw ? ni : m_ins + 64'(instret);
`endif
    endtask

    logic [11:0] addr_pool[20];

    task automatic rand_port(output logic [11:0] a, output logic w, output logic [31:0] d);
        logic [4:0] idx;
        idx = 5'($urandom_range(0, 19));
        a   = (idx == 5'd19) ? 12'($urandom) : addr_pool[idx];
        w   = ($urandom_range(0, 1) == 1);
        d   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
    endtask

    initial begin
        addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                      12'hC82, 12'hF14, 12'h7C0, 12'h000};

        tbl.push_back(mk("rst_rd",   12'h300,0,0,            12'h305,0,0,            12'h301,0,0,
                         32'h0000_1800, 32'h0, MISA_EXP, 1'b0));
        tbl.push_back(mk("mtvec_wr", 12'h305,1,32'h8000_0103, 12'h305,0,0,           12'hF14,0,0,
                         32'h0, 32'h0, HART_EXP, 1'b0));
        tbl.push_back(mk("mepc_wr",  12'h341,1,32'h0000_0106, 12'h305,0,0,           12'h000,0,0,
                         32'h0, 32'h8000_0100, 32'h0, 1'b0));
        tbl.push_back(mk("mepc_rd",  12'h341,0,0,            12'h305,1,32'h200,      12'h000,0,0,
                         32'h0000_0104, 32'h8000_0100, 32'h0, 1'b0));
        tbl.push_back(mk("trap",     12'h342,1,MCAUSE_ECALL_M, 12'h341,1,32'h100,    12'h305,0,0,
                         32'h0, 32'h0000_0104, 32'h200, 1'b0));
        tbl.push_back(mk("trap_nx",  12'h342,0,0,            12'h341,0,0,            12'h344,0,0,
                         32'd11, 32'h100, 32'h0, 1'b0));
        tbl.push_back(mk("collide",  12'h340,1,32'hAAAA_AAAA, 12'h000,0,0,           12'h340,1,32'h5555_5555,
                         32'h0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk("coll_rd",  12'h340,0,0,            12'h300,1,32'hFFFF_FFFF, 12'h000,0,0,
                         32'hAAAA_AAAA, 32'h0000_1800, 32'h0, 1'b0));
        tbl.push_back(mk("mstatus",  12'h300,0,0,            12'h301,1,32'h0,        12'h344,1,32'hFFFF_FFFF,
                         32'h0000_1888, MISA_EXP, 32'h0, 1'b0));
        tbl.push_back(mk("ro_keep",  12'h301,0,0,            12'hF14,1,32'h1234,     12'h344,0,0,
                         MISA_EXP, HART_EXP, 32'h0, 1'b0));
        tbl.push_back(mk("unimpl",   12'h7C0,0,0,            12'hF14,0,0,            12'h000,0,0,
                         32'h0, HART_EXP, 32'h0, 1'b1));
        tbl.push_back(mk("wr_hart",  12'hF14,1,32'h5,        12'h304,1,32'hDEAD_BEEF, 12'h343,1,32'h1234_5678,
                         HART_EXP, 32'h0, 32'h0, 1'b1));
        tbl.push_back(mk("wr_misa",  12'h301,1,32'h5,        12'h304,0,0,            12'h343,0,0,
                         MISA_EXP, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0));
        tbl.push_back(mk("p2_p3",    12'h344,1,32'h1,        12'h340,1,32'h1,        12'h340,1,32'h2,
                         32'h0, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b0));
        tbl.push_back(mk("p2_win",   12'h340,0,0,            12'h342,0,0,            12'h000,0,0,
                         32'h1, 32'd11, 32'h0, 1'b0));

        // Reset held for two edges with a pending write that must be discarded.
        rst_n = 1'b0; instret = 1'b1;
        drive(12'h340,1,32'h77, 12'h305,1,32'h44, 12'hB00,1,32'h9);
        tick(); tick();
        rst_n = 1'b1; instret = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].a1, tbl[i].w1, tbl[i].d1, tbl[i].a2, tbl[i].w2, tbl[i].d2,
                  tbl[i].a3, tbl[i].w3, tbl[i].d3);
            #1;
            chk4(tbl[i].name, tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].eill);
            tick();
        end

`ifdef CSR_COUNTERS_EN
        // Carry from low to high word, with minstret counting only on instret cycles.
        drive(12'hB00,1,32'hFFFF_FFFE, 12'hB80,1,32'h0, 12'hB02,0,0);
        #1; chk("cnt_wr.ill", 32'(ill1), 32'h0);
        tick();
        instret = 1'b1;
        drive(12'hB00,0,0, 12'hB80,0,0, 12'hB02,0,0);
        #1; chk4("cnt_c0", 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b0);
        tick();
        instret = 1'b0;
        #1; chk4("cnt_c1", 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        tick();
        instret = 1'b1;
        drive(12'hB00,0,0, 12'hC80,0,0, 12'hC02,0,0);
        #1; chk4("cnt_c2", 32'h0, 32'h1, 32'h1, 1'b0);
        tick();
        instret = 1'b0;
        drive(12'hC00,1,32'h5, 12'hB02,0,0, 12'hC82,0,0);
        #1; chk4("cyc_ro", 32'h1, 32'h2, 32'h0, 1'b1);
        tick();
        instret = 1'b1;
        drive(12'hC00,0,0, 12'hB80,0,0, 12'hB82,1,32'h7);
        #1; chk4("cyc_cont", 32'h2, 32'h1, 32'h0, 1'b0);
        tick();
        instret = 1'b0;
        drive(12'hC82,0,0, 12'hC02,0,0, 12'h000,0,0);
        #1; chk4("ins_hold", 32'h7, 32'h2, 32'h0, 1'b0);
        tick();
`else
        instret = 1'b1;
        drive(12'hB00,0,0, 12'hC82,0,0, 12'hB02,1,32'h9);
        #1; chk4("nocnt_rd", 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        drive(12'hB02,1,32'h3, 12'hB00,0,0, 12'hC00,0,0);
        #1; chk4("nocnt_wr", 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        instret = 1'b0;
`endif

        // Reset must win over writes and counting in the same cycle.
        rst_n = 1'b0; instret = 1'b1;
        drive(12'h340,1,32'h77, 12'h341,1,32'h40, 12'hB00,1,32'h5);
        tick();
        rst_n = 1'b1; instret = 1'b0;
        drive(12'h340,0,0, 12'h300,0,0, 12'hB00,0,0);
        #1; chk4("rst_win", 32'h0, 32'h0000_1800, 32'h0, 1'b0);
        tick();

        // Randomized traffic checked against the reference model.
        rst_n = 1'b0;
        drive(12'h0,0,0, 12'h0,0,0, 12'h0,0,0);
        tick();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            logic [11:0] x;
            logic        y;
            logic [31:0] z;
            rst_n   = ($urandom_range(0, 49) != 0);
            instret = ($urandom_range(0, 1) == 1);
            rand_port(x, y, z); a1 = x; w1 = y; d1 = z;
            rand_port(x, y, z); a2 = x; w2 = y; d2 = z;
            rand_port(x, y, z); a3 = x; w3 = y; d3 = z;
            #1;
            chk("rnd.rd1", rd1, m_read(a1));
            chk("rnd.rd2", rd2, m_read(a2));
            chk("rnd.rd3", rd3, m_read(a3));
            chk("rnd.ill", 32'(ill1), 32'(m_illegal(a1, w1)));
            m_step();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
